// File: rtl/gate_array_pipe.sv
// gate_array_pipe: two-stage bitwise logic unit with a popcount of the result.
// Stage 1 registers op(a,b); stage 2 registers that result plus its popcount.
// Both stages advance together whenever the output register is empty or being
// drained, so a stalled output freezes the whole pipe and back-pressures input.
`default_nettype none

module gate_array_pipe #(
   parameter int WIDTH = 4,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out,
   output logic [CW-1:0]    ones,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      txn_count
);

   // Operation codes
   localparam logic [2:0] OP_NAND  = 3'b000;
   localparam logic [2:0] OP_AND   = 3'b001;
   localparam logic [2:0] OP_OR    = 3'b010;
   localparam logic [2:0] OP_NOR   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_XNOR  = 3'b101;
   localparam logic [2:0] OP_NOTA  = 3'b110;
   localparam logic [2:0] OP_PASSA = 3'b111;

   // Single-bit gate evaluation; every code is legal, b is ignored for NOTA/PASSA.
   function automatic logic bit_op(input logic [2:0] sel, input logic x, input logic y);
      logic r;
      case (sel)
         OP_NAND:  r = ~(x & y);
         OP_AND:   r = x & y;
         OP_OR:    r = x | y;
         OP_NOR:   r = ~(x | y);
         OP_XOR:   r = x ^ y;
         OP_XNOR:  r = ~(x ^ y);
         OP_NOTA:  r = ~x;
         OP_PASSA: r = x;
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   logic             en;
   logic [WIDTH-1:0] s1_next;
   logic [WIDTH-1:0] s1_data;
   logic             s1_valid;
   logic [CW-1:0]    s1_pop;
   logic [WIDTH-1:0] s2_data;
   logic [CW-1:0]    s2_ones;
   logic             s2_valid;
   logic [15:0]      txn_reg;

   // The pipe moves only when the output slot is free or is being taken this cycle.
   assign en       = !s2_valid || out_ready;
   assign in_ready = en;

   // One gate per operand bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign s1_next[gi] = bit_op(op, a[gi], b[gi]);
   end

   // Population count of the stage-1 result, registered alongside it in stage 2.
   always_comb begin
      s1_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         s1_pop = s1_pop + CW'(s1_data[i]);
      end
   end

   // Stage 1: capture the gate result; valid follows in_valid so bubbles propagate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_data  <= s1_next;
      end
   end

   // Stage 2: output register; holds its contents whenever the pipe is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_ones  <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            // Keep the last delivered result visible while bubbles pass through.
            s2_data <= s1_data;
            s2_ones <= s1_pop;
         end
      end
   end

   // Count output handshakes; the 16-bit counter wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_reg <= 16'h0000;
      end else if (s2_valid && out_ready) begin
         txn_reg <= txn_reg + 16'd1;
      end
   end

   assign out       = s2_data;
   assign ones      = s2_ones;
   assign out_valid = s2_valid;
   assign txn_count = txn_reg;

endmodule

`default_nettype wire

// File: tb/tb_gate_array_pipe.sv
// Bench for gate_array_pipe (WIDTH=4): directed vectors with literal expectations
// plus a scoreboard model that checks every output beat in order.
`timescale 1ns/1ps

module tb_gate_array_pipe;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = 3'b000;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out;
   logic [2:0]   ones;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [15:0]  txn_count;

   int compared = 0;
   int mismatched = 0;

   gate_array_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .ones      (ones),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .txn_count (txn_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Specification-level model of one operation.
   function automatic logic [W-1:0] model_result(input logic [2:0] o, input logic [W-1:0] x,
                                                  input logic [W-1:0] y);
      case (o)
         3'd0: return ~(x & y);
         3'd1: return x & y;
         3'd2: return x | y;
         3'd3: return ~(x | y);
         3'd4: return x ^ y;
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return x;
      endcase
   endfunction

   function automatic int model_ones(input logic [W-1:0] v);
      int n = 0;
      for (int i = 0; i < W; i++) if (v[i]) n++;
      return n;
   endfunction

   // Scoreboard: accepted results in order, and a handshake counter.
   logic [W-1:0] exp_q[$];
   logic [15:0]  model_txn = 16'h0000;

   // Sample between edges: compare the presented beat, then record what the next edge will do.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         model_txn = 16'h0000;
      end else begin
         check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid) || out_ready});
         check("txn_count", {16'd0, txn_count}, {16'd0, model_txn});
         if (out_valid) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               check("sb_out", {28'd0, out}, {28'd0, exp_q[0]});
               check("sb_ones", {29'd0, ones}, model_ones(exp_q[0]));
            end
            if (out_ready) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               model_txn += 16'd1;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model_result(op, a, b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
   endtask

   task automatic pulse_reset();
      tick();
      #1 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Single operation: invisible after the accepting edge, valid after the next one.
   task automatic one_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp_out, input logic [2:0] exp_ones);
      tick();
      out_ready = 1'b1;
      drive(o, x, y);
      tick();
      in_valid = 1'b0;
      check("lat_early_valid", {31'd0, out_valid}, 0);
      tick();
      check("lat_valid", {31'd0, out_valid}, 1);
      check("op_out", {28'd0, out}, {28'd0, exp_out});
      check("op_ones", {29'd0, ones}, {29'd0, exp_ones});
   endtask

   logic [W-1:0] exp_ops [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                                 4'b0110, 4'b1001, 4'b0011, 4'b1100};
   logic [2:0]   exp_pop [8] = '{3'd3, 3'd1, 3'd3, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2};
   logic [W-1:0] nand_a  [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111};
   logic [W-1:0] nand_b  [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
   logic [W-1:0] nand_r  [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
   logic         bub_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Pin the model with hand-computed values.
      check("model_nand", {28'd0, model_result(3'd0, 4'b1100, 4'b1010)}, 32'h7);
      check("model_xnor", {28'd0, model_result(3'd5, 4'b1100, 4'b1010)}, 32'h9);
      check("model_nota", {28'd0, model_result(3'd6, 4'b1100, 4'b1010)}, 32'h3);
      check("model_ones", model_ones(4'b1011), 3);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out", {28'd0, out}, 0);
      check("rst_ones", {29'd0, ones}, 0);
      check("rst_txn", {16'd0, txn_count}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 1);
      rst = 1'b0;

      // All eight op codes on a=1100, b=1010
      for (int i = 0; i < 8; i++) one_op(3'(i), 4'b1100, 4'b1010, exp_ops[i], exp_pop[i]);

      // Back-to-back NAND stream over the truth-table pairs
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i >= 2) begin
            check("nand_valid", {31'd0, out_valid}, 1);
            check("nand_out", {28'd0, out}, {28'd0, nand_r[i-2]});
         end
         if (i < 4) drive(3'd0, nand_a[i], nand_b[i]);
         else in_valid = 1'b0;
      end
      tick();
      check("nand_txn", {16'd0, txn_count}, 4);
      check("nand_drained", {31'd0, out_valid}, 0);

      // Output stall for five cycles with three inputs offered
      tick();
      out_ready = 1'b0;
      drive(3'd1, 4'b1111, 4'b0101);          // -> 0101
      tick();
      drive(3'd2, 4'b0001, 4'b0010);          // -> 0011
      tick();
      drive(3'd4, 4'b1111, 4'b0001);          // -> 1110, held until accepted
      check("stall_in_ready", {31'd0, in_ready}, 0);
      check("stall_valid", {31'd0, out_valid}, 1);
      check("stall_out0", {28'd0, out}, 32'h5);
      tick();
      tick();
      check("stall_hold_out", {28'd0, out}, 32'h5);
      check("stall_hold_ones", {29'd0, ones}, 2);
      check("stall_hold_ready", {31'd0, in_ready}, 0);
      tick();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("release_out1", {28'd0, out}, 32'h3);
      tick();
      check("release_out2", {28'd0, out}, 32'he);
      check("release_ones2", {29'd0, ones}, 3);
      tick();
      check("release_done", {31'd0, out_valid}, 0);

      // Handshake counter wrap
      pulse_reset();
      tick();
      out_ready = 1'b1;
      drive(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      for (int k = 1; k <= 65537; k++) begin
         tick();
         drive(3'($urandom_range(7)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      end
      check("txn_65535", {16'd0, txn_count}, 32'hFFFF);
      tick();
      in_valid = 1'b0;
      check("txn_wrap", {16'd0, txn_count}, 0);
      repeat (3) tick();

      // Asynchronous reset with two results in flight
      tick();
      out_ready = 1'b1;
      drive(3'd1, 4'b1111, 4'b1111);          // -> 1111
      tick();
      drive(3'd2, 4'b1000, 4'b0001);          // -> 1001
      tick();
      in_valid = 1'b0;
      check("inflight_valid", {31'd0, out_valid}, 1);
      check("inflight_out", {28'd0, out}, 32'hf);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", {31'd0, out_valid}, 0);
      check("arst_out", {28'd0, out}, 0);
      check("arst_ones", {29'd0, ones}, 0);
      check("arst_txn", {16'd0, txn_count}, 0);
      check("arst_in_ready", {31'd0, in_ready}, 1);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_stale_valid", {31'd0, out_valid}, 0);
         check("no_stale_out", {28'd0, out}, 0);
      end
      one_op(3'd3, 4'b0100, 4'b0010, 4'b1001, 3'd2);

      // Bubbles: in_valid 1,0,1,0
      tick();
      for (int i = 0; i < 7; i++) begin
         if (i >= 2 && i < 6) check("bubble_valid", {31'd0, out_valid}, {31'd0, bub_pat[i-2]});
         if (i < 4) begin
            drive(3'(3 + 2 * (i / 2)), 4'b1010, 4'b1010);   // NOR then XNOR
            in_valid = bub_pat[i];
         end else begin
            in_valid = 1'b0;
         end
         if (i < 6) tick();
      end

      tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gate_array_pipe.md
GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and result width in bits (legal range 1..32).
REQ-002 Parameter CW, default $clog2(WIDTH+1), SHALL set the popcount width (derived; not overridden).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 a  input  WIDTH  SHALL be operand A.
REQ-006 b  input  WIDTH  SHALL be operand B.
REQ-007 op  input  3  SHALL be the operation select, sampled with a and b.
REQ-008 in_valid  input  1  SHALL qualify a, b and op.
REQ-009 in_ready  output  1  SHALL indicate that the block accepts an input this cycle.
REQ-010 out  output  WIDTH  SHALL be the bitwise result.
REQ-011 ones  output  CW  SHALL be the popcount of out.
REQ-012 out_valid  output  1  SHALL qualify out and ones.
REQ-013 out_ready  input  1  SHALL indicate that the downstream block accepts the output.
REQ-014 txn_count  output  16  SHALL count completed output handshakes.

Function
REQ-015 op encoding SHALL be: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 ~a, 111 a; all codes are legal and b is ignored for 110 and 111.
REQ-016 The pipeline SHALL have two stages: S1 registers op(a,b) and a valid bit; S2 registers S1's result, popcount(S1 result) and a valid bit; out/ones/out_valid SHALL be driven directly from S2.
REQ-017 Advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-018 Input acceptance SHALL occur when in_valid & in_ready are both high at a rising edge.
REQ-019 When en=1: S1 SHALL load the new result with valid=in_valid; S2 SHALL load S1 contents including its valid bit (bubbles propagate).
REQ-020 When en=0: S1 and S2 SHALL hold all contents, and out and ones SHALL remain stable while out_valid=1.
REQ-021 Latency SHALL be 2 cycles: an input accepted at edge N SHALL appear with out_valid=1 after edge N+1, provided there is no stall.
REQ-022 Throughput SHALL be one result per cycle while out_ready=1.
REQ-023 An output handshake SHALL occur when out_valid & out_ready are both high at a rising edge; each handshake SHALL increment txn_count by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-024 When a handshake and an acceptance occur on the same edge, both SHALL complete; no data SHALL be lost or duplicated.
REQ-025 Outputs SHALL never present X after reset; S1 and S2 data registers SHALL load only when en=1.
REQ-026 ones SHALL be the exact count of 1 bits in out (0..WIDTH); when out_valid=0, out and ones SHALL hold their last values.

Reset
REQ-027 Asserting rst SHALL immediately and asynchronously clear the S1/S2 valid bits, out, ones and txn_count to 0, regardless of clk.
REQ-028 When out_valid=0 during reset, in_ready SHALL be 1 (en=1).
REQ-029 Reset asserted mid-stream SHALL discard all in-flight results; the first input accepted after deassertion SHALL follow REQ-021.
REQ-030 Reset deassertion SHALL take effect at the next rising edge, with no further sequencing required.

Verification (WIDTH=4)
REQ-031 All 8 op codes with a=4'b1100, b=4'b1010, out_ready=1 -> out = 0111, 1000, 1110, 0001, 0110, 1001, 0011, 1100 respectively; ones = 3,1,3,1,2,2,2,2 respectively; each result 2 cycles after acceptance.
REQ-032 Stream of 4 back-to-back NAND inputs covering the truth-table pairs a,b in {0000,1111}, out_ready=1 -> 4 consecutive out_valid cycles, results in order, txn_count=4.
REQ-033 out_ready=0 for 5 cycles with 3 inputs offered -> in_ready drops once out_valid=1, out stays stable, no data lost; on release, all accepted results delivered in order.
REQ-034 txn_count preset by 65535 handshakes, then one more handshake -> txn_count=0.
REQ-035 rst pulsed between edges with 2 results in flight -> out_valid, out, ones and txn_count are 0 immediately, and no stale result appears after release.
REQ-036 in_valid toggled 1,0,1,0 with out_ready=1 -> out_valid follows 1,0,1,0 delayed by 2 cycles, with bubbles preserved.
